// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and size helpers for the row collector
package matrix_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

    function automatic int row_bytes(int n, int bits);
        return n * bits / 8;
    endfunction

    function automatic int mat_bytes(int n, int bits);
        return n * n * bits / 8;
    endfunction
endpackage

// File: rtl/c_row_mem.sv
// c_row_mem: N x row register array with accumulating row write and registered byte read
module c_row_mem
    import matrix_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N = 8,
    parameter int ROW_AW = 3,
    parameter int RD_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic                accum,
    input  logic [ROW_AW-1:0]   wr_idx,
    input  logic [N*BITS-1:0]   wr_row,
    input  logic                rd_en,
    input  logic [RD_AW-1:0]    rd_addr,
    output logic [7:0]          rd_data,
    output logic                rd_valid
);
    localparam int ROW_BYTES = row_bytes(N, BITS);
    localparam int MAT_BYTES = mat_bytes(N, BITS);

    typedef logic [N-1:0][BITS-1:0] row_t;

    row_t mem [N];
    row_t in_row;
    logic [N*BITS-1:0] rd_row;
    logic [ROW_AW-1:0] ri;
    int off;

    assign in_row = wr_row;

    // Elements are little-endian and packed contiguously, so a row byte offset is a plain bit offset
    always_comb begin
        ri = ROW_AW'(int'(rd_addr) / ROW_BYTES);
        off = int'(rd_addr) % ROW_BYTES;
        rd_row = mem[ri];
    end

    always_ff @(posedge clk)
        if (wr)
            for (int i = 0; i < N; i++)
                mem[wr_idx][i] <= accum ? mem[wr_idx][i] + in_row[i] : in_row[i];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_data <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= int'(rd_addr) >= MAT_BYTES ? 8'h00 : rd_row[off*8 +: 8];
        end
endmodule

// File: rtl/c_row_collector.sv
// c_row_collector: captures N strobed partial-product rows into a matrix and serves it bytewise
module c_row_collector
    import matrix_pkg::*;
#(
    parameter int BITS = 8,
    parameter int N = 8,
    parameter int ROW_AW = 3,
    parameter int RD_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                accum,
    input  logic [N*BITS-1:0]   row_in,
    input  logic                row_wr,
    input  logic                rd_en,
    input  logic [RD_AW-1:0]    rd_addr,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic                done,
    output logic                ovf
);
    state_t state;
    logic [ROW_AW-1:0] cnt;
    logic accum_q;
    logic wr;

    // start takes priority, so a coincident strobe is dropped
    assign wr = row_wr && !start && state == CAPTURE;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            accum_q <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
        end else if (start) begin
            state <= CAPTURE;
            cnt <= '0;
            accum_q <= accum;
            busy <= 1'b1;
            done <= 1'b0;
            ovf <= 1'b0;
        end else if (row_wr) begin
            if (state == CAPTURE) begin
                cnt <= cnt + 1'b1;
                if (cnt == ROW_AW'(N - 1)) begin
                    state <= FULL;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else
                ovf <= 1'b1;
        end

    c_row_mem #(.BITS(BITS), .N(N), .ROW_AW(ROW_AW), .RD_AW(RD_AW)) u_mem (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .accum(accum_q),
        .wr_idx(cnt),
        .wr_row(row_in),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid)
    );
endmodule
